fetch_unit: RTL and testbench

- Instruction-fetch front end that owns the PC.
- Runs a request/acknowledge handshake with instruction memory and presents the fetched word on Instr to the controller.
- Consumes PCSrc and Result from the controller/datapath to select the next PC.
- Emits a one-cycle exec_en strobe; downstream register, flag and memory writes are gated by it, so instructions execute exactly once despite variable memory latency.

---
 rtl/fetch_unit_pkg.sv | 8 +
 rtl/fetch_watchdog.sv | 25 ++
 rtl/fetch_unit.sv | 72 +++++++
 tb/tb_fetch_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_unit_pkg;
  typedef enum logic [1:0] {BOOT, FETCH, EXEC, FAULT} fetch_state_t;

  localparam logic [31:0] NOP_INSTR      = 32'hE1A0_0000;
  localparam logic [31:0] INSTR_BYTES    = 32'd4;
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;
endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive FETCH cycles without an ack; flags the edge on which
// the count would reach TIMEOUT. TIMEOUT = 0 disables the watchdog.
module fetch_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);
  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (clear) cnt <= '0;
    else if (run)   cnt <= cnt + 1'b1;
  end

  // clear (an ack) outranks expiry on the same cycle
  assign expired = (TIMEOUT != 0) && run && !clear && (cnt == LAST);
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, handshakes with imem, and strobes exec_en
// once per instruction regardless of memory latency.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic        exec_en,
  input  logic        PCSrc,
  input  logic [31:0] Result,
  input  logic        stall,
  output logic [31:0] PC,
  output logic [31:0] PCPlus8,
  output logic        fetch_fault
);
  fetch_state_t state;
  logic in_fetch, expired;
  logic unused_result_bits;

  assign in_fetch = (state == FETCH);

  fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .run     (in_fetch && !imem_ack),
    .clear   (!in_fetch || imem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      PC    <= RESET_PC;
      Instr <= NOP_INSTR;
    end else begin
      case (state)
        BOOT:  state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            Instr <= imem_rdata;
            state <= EXEC;
          end else if (expired) begin
            state <= FAULT;
          end
        end
        EXEC: begin
          if (!stall) begin
            PC    <= PCSrc ? {Result[31:2], 2'b00} : PC + INSTR_BYTES;
            state <= FETCH;
          end
        end
        default: state <= FAULT;
      endcase
    end
  end

  assign imem_req    = in_fetch;
  assign imem_addr   = PC;
  assign exec_en     = (state == EXEC) && !stall;
  assign fetch_fault = (state == FAULT);
  assign PCPlus8     = PC + PC_READ_OFFSET;

  assign unused_result_bits = ^Result[1:0];
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a default instance (a_*) and one with
// RESET_PC = 32'hFFFF_FFFC, TIMEOUT = 4 (b_*) share every input.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        reset, imem_ack, PCSrc, stall;
  logic [31:0] imem_rdata, Result;

  logic        a_imem_req, a_exec_en, a_fetch_fault;
  logic [31:0] a_imem_addr, a_Instr, a_PC, a_PCPlus8;
  logic        b_imem_req, b_exec_en, b_fetch_fault;
  logic [31:0] b_imem_addr, b_Instr, b_PC, b_PCPlus8;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(64)) dut_a (
    .clk(clk), .reset(reset), .imem_req(a_imem_req), .imem_addr(a_imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .Instr(a_Instr),
    .exec_en(a_exec_en), .PCSrc(PCSrc), .Result(Result), .stall(stall),
    .PC(a_PC), .PCPlus8(a_PCPlus8), .fetch_fault(a_fetch_fault)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(4)) dut_b (
    .clk(clk), .reset(reset), .imem_req(b_imem_req), .imem_addr(b_imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .Instr(b_Instr),
    .exec_en(b_exec_en), .PCSrc(PCSrc), .Result(Result), .stall(stall),
    .PC(b_PC), .PCPlus8(b_PCPlus8), .fetch_fault(b_fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    PCSrc = 1'b0; Result = '0; stall = 1'b0;
    tick(); tick();
    checks++; if (a_imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", a_imem_req); end
    checks++; if (a_exec_en !== 1'b0) begin errors++; $display("FAIL reset_exec: got %b want 0", a_exec_en); end
    checks++; if (a_PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", a_PC); end
    checks++; if (a_Instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", a_Instr, NOP); end
    checks++; if (a_fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", a_fetch_fault); end
    checks++; if (b_PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_pc_b: got %h want fffffffc", b_PC); end
    checks++; if (b_PCPlus8 !== 32'h0000_0004) begin errors++; $display("FAIL pcplus8_wrap: got %h want 00000004", b_PCPlus8); end
    reset = 1'b0;
    #1;
    checks++; if (a_imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b want 0", a_imem_req); end
  endtask

  task automatic test_ack_high();
    imem_ack = 1'b1; imem_rdata = 32'hE3A0_0001;
    tick();
    checks++; if (a_imem_req !== 1'b1 || a_imem_addr !== 32'h0) begin errors++; $display("FAIL first_fetch: got req=%b addr=%h want req=1 addr=00000000", a_imem_req, a_imem_addr); end
    checks++; if (a_Instr !== NOP || a_exec_en !== 1'b0) begin errors++; $display("FAIL pre_ack_instr: got %h exec=%b want %h exec=0", a_Instr, a_exec_en, NOP); end
    checks++; if (b_imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL first_fetch_b: got %h want fffffffc", b_imem_addr); end
    tick();
    checks++; if (a_exec_en !== 1'b1 || a_Instr !== 32'hE3A0_0001 || a_PC !== 32'h0) begin errors++; $display("FAIL exec0: got exec=%b instr=%h pc=%h want 1 e3a00001 00000000", a_exec_en, a_Instr, a_PC); end
    checks++; if (b_exec_en !== 1'b1) begin errors++; $display("FAIL exec0_b: got %b want 1", b_exec_en); end
    tick();
    checks++; if (a_exec_en !== 1'b0 || a_imem_addr !== 32'h4) begin errors++; $display("FAIL fetch4: got exec=%b addr=%h want 0 00000004", a_exec_en, a_imem_addr); end
    checks++; if (b_imem_addr !== 32'h0) begin errors++; $display("FAIL pc_wrap_b: got %h want 00000000", b_imem_addr); end
    tick();
    checks++; if (a_exec_en !== 1'b1 || a_PC !== 32'h4) begin errors++; $display("FAIL exec4: got exec=%b pc=%h want 1 00000004", a_exec_en, a_PC); end
    tick();
    checks++; if (a_imem_addr !== 32'h8) begin errors++; $display("FAIL fetch8: got %h want 00000008", a_imem_addr); end
    imem_ack = 1'b0;
  endtask

  task automatic test_delayed_ack();
    int held = 0;
    int execs = 0;
    imem_rdata = 32'hE3A0_1005;
    for (int j = 0; j < 5; j++) begin
      if (a_imem_req && a_imem_addr == 32'h8) held++;
      if (a_exec_en) execs++;
      imem_ack = (j == 3);
      if (j < 4) tick();
    end
    checks++; if (held != 4) begin errors++; $display("FAIL addr_hold: got %0d cycles want 4", held); end
    checks++; if (execs != 1) begin errors++; $display("FAIL exec_once: got %0d strobes want 1", execs); end
    checks++; if (a_Instr !== 32'hE3A0_1005) begin errors++; $display("FAIL delayed_instr: got %h want e3a01005", a_Instr); end
    checks++; if (b_fetch_fault !== 1'b0 || b_exec_en !== 1'b1) begin errors++; $display("FAIL ack_beats_timeout: got fault=%b exec=%b want 0 1", b_fetch_fault, b_exec_en); end
  endtask

  task automatic test_branch();
    PCSrc = 1'b1; Result = 32'h0000_0103;
    tick();
    checks++; if (a_imem_addr !== 32'h100) begin errors++; $display("FAIL branch_target: got %h want 00000100", a_imem_addr); end
    PCSrc = 1'b0; Result = '0; imem_ack = 1'b1;
    tick();
    checks++; if (a_exec_en !== 1'b1 || a_PC !== 32'h100) begin errors++; $display("FAIL branch_exec: got exec=%b pc=%h want 1 00000100", a_exec_en, a_PC); end
    imem_ack = 1'b0;
    tick();
    checks++; if (a_imem_addr !== 32'h104) begin errors++; $display("FAIL seq_after_branch: got %h want 00000104", a_imem_addr); end
  endtask

  task automatic test_stall();
    int stalled_exec = 0;
    int pc_moved = 0;
    imem_ack = 1'b1;
    tick();
    stall = 1'b1; PCSrc = 1'b1; Result = 32'h40; imem_rdata = 32'hDEAD_BEEF;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (a_exec_en) stalled_exec++;
      if (a_PC != 32'h104) pc_moved++;
      tick();
    end
    checks++; if (stalled_exec != 0) begin errors++; $display("FAIL stall_exec: got %0d strobes want 0", stalled_exec); end
    checks++; if (pc_moved != 0) begin errors++; $display("FAIL stall_pc: got %0d moves want 0", pc_moved); end
    checks++; if (a_Instr !== 32'hE3A0_1005) begin errors++; $display("FAIL exec_ack_ignored: got %h want e3a01005", a_Instr); end
    stall = 1'b0; imem_ack = 1'b0;
    #1;
    checks++; if (a_exec_en !== 1'b1) begin errors++; $display("FAIL stall_release: got %b want 1", a_exec_en); end
    tick();
    PCSrc = 1'b0; Result = '0;
    checks++; if (a_imem_addr !== 32'h40) begin errors++; $display("FAIL stall_branch: got %h want 00000040", a_imem_addr); end
  endtask

  task automatic test_timeout();
    int early = 0;
    for (int k = 0; k < 4; k++) begin
      if (!b_imem_req || b_fetch_fault) early++;
      tick();
    end
    checks++; if (early != 0) begin errors++; $display("FAIL timeout_early: got %0d bad cycles want 0", early); end
    checks++; if (b_fetch_fault !== 1'b1 || b_imem_req !== 1'b0 || b_exec_en !== 1'b0) begin errors++; $display("FAIL timeout_fault: got fault=%b req=%b exec=%b want 1 0 0", b_fetch_fault, b_imem_req, b_exec_en); end
    checks++; if (a_imem_req !== 1'b1 || a_fetch_fault !== 1'b0) begin errors++; $display("FAIL long_timeout: got req=%b fault=%b want 1 0", a_imem_req, a_fetch_fault); end
    tick(); tick(); tick();
    checks++; if (b_fetch_fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b want 1", b_fetch_fault); end
    reset = 1'b1;
    #1;
    checks++; if (b_fetch_fault !== 1'b0 || b_PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL fault_reset: got fault=%b pc=%h want 0 fffffffc", b_fetch_fault, b_PC); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (b_imem_req !== 1'b1 || b_imem_addr !== 32'hFFFF_FFFC || a_imem_addr !== 32'h0) begin errors++; $display("FAIL restart_fetch: got b_req=%b b_addr=%h a_addr=%h want 1 fffffffc 00000000", b_imem_req, b_imem_addr, a_imem_addr); end
  endtask

  task automatic test_reset_midfetch();
    #3;
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (a_Instr !== NOP || a_exec_en !== 1'b0 || a_imem_req !== 1'b0) begin errors++; $display("FAIL midfetch_reset: got instr=%h exec=%b req=%b want %h 0 0", a_Instr, a_exec_en, a_imem_req, NOP); end
    tick();
    checks++; if (a_Instr !== NOP || a_exec_en !== 1'b0) begin errors++; $display("FAIL boot_ack_ignored: got instr=%h exec=%b want %h 0", a_Instr, a_exec_en, NOP); end
    imem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ack_high();
    test_delayed_ack();
    test_branch();
    test_stall();
    test_timeout();
    test_reset_midfetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
